// File: rtl/node_mem_pkg.sv
// Shared definitions for the node data memory: geometry, memory map,
// requester indices and the port arbiter state encoding.
package node_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] NEIGHBOR_ID_BASE = 11'h048;
  localparam logic [ADDR_W-1:0] BATTERY_BASE     = 11'h148;
  localparam logic [ADDR_W-1:0] QVALUE_BASE      = 11'h1C8;
  localparam int                WORD_STRIDE      = 2;

  localparam int REQ_REWARD  = 0;
  localparam int REQ_BESTHOP = 1;
  localparam int REQ_QUPDATE = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Address of entry idx in a table starting at base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input int unsigned idx);
    return base + ADDR_W'(idx * WORD_STRIDE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first candidate after i_last (with
// wrap-around) that is requesting and not masked by i_excl.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  input  logic [NREQ-1:0]  i_excl,
  output logic [NREQ-1:0]  o_pick,
  output logic             o_valid
);

  logic [NREQ-1:0]  w_cand;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      // i_last + k never exceeds 2*NREQ-1, so one conditional subtract wraps it.
      w_sum = {1'b0, i_last} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NREQ))
        w_sum = w_sum - (IDX_W+1)'(NREQ);
      w_idx = w_sum[IDX_W-1:0];
      if (!o_valid && w_cand[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Burst-granting round-robin arbiter for the single-port node data memory,
// with a hold watchdog that preempts an owner starving other requesters.
module mem_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = node_mem_pkg::ADDR_W,
  parameter int DATA_W   = node_mem_pkg::DATA_W,
  parameter int MAX_HOLD = 64
) (
  input  logic                   clock,
  input  logic                   nrst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        grant,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        rvalid,
  output logic [NREQ-1:0]        preempt,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  import node_mem_pkg::*;

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [NREQ-1:0]  r_grant, w_grant_nxt;
  logic [NREQ-1:0]  r_preempt, w_preempt_nxt;
  logic [NREQ-1:0]  r_rvalid;
  logic [IDX_W-1:0] r_last_owner, w_last_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;

  logic [IDX_W-1:0] w_owner_idx;
  logic [IDX_W-1:0] w_pick_last;
  logic             w_owner_req;
  logic             w_others;
  logic [NREQ-1:0]  w_pick;
  logic             w_pick_vld;

  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (r_grant[i]) w_owner_idx = IDX_W'(i);
  end

  assign w_owner_req = |(r_grant & req);
  assign w_others    = |(req & ~r_grant);

  // While owning, the scan starts after the current owner and skips it, which
  // serves IDLE, release and preemption with the same picker.
  assign w_pick_last = (r_state == ST_OWN) ? w_owner_idx : r_last_owner;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (w_pick_last),
    .i_excl  (r_grant),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last_owner;
    w_hold_nxt    = r_hold_cnt;
    w_preempt_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_OWN;
          w_hold_nxt  = '0;
        end
      end
      ST_OWN: begin
        if (!w_owner_req) begin
          w_last_nxt = w_owner_idx;
          w_hold_nxt = '0;
          if (w_pick_vld) begin
            w_grant_nxt = w_pick;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_others && r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
          w_preempt_nxt = r_grant;
          w_last_nxt    = w_owner_idx;
          w_grant_nxt   = w_pick;
          w_hold_nxt    = '0;
        end else if (w_others && r_hold_cnt != CNT_W'(MAX_HOLD)) begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_preempt    <= '0;
      r_rvalid     <= '0;
      r_last_owner <= IDX_W'(NREQ - 1);
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_preempt    <= w_preempt_nxt;
      r_rvalid     <= r_grant & req & ~req_we;
      r_last_owner <= w_last_nxt;
      r_hold_cnt   <= w_hold_nxt;
    end
  end

  // Memory port mux follows the registered grant; writes need a live req.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
        mem_we    = req_we[i] & req[i];
      end
    end
  end

  assign grant   = r_grant;
  assign preempt = r_preempt;
  assign rvalid  = r_rvalid;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory environment, behavioural arbitration
// model with per-cycle comparison, and directed scenarios with literal checks.
module tb_mem_port_arbiter;

  import node_mem_pkg::*;

  localparam int NREQ = 3;
  localparam int MH   = 4;

  logic                   clock;
  logic                   nrst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        grant;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        rvalid;
  logic [NREQ-1:0]        preempt;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mem_port_arbiter #(
    .NREQ     (NREQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MH)
  ) dut (
    .clock     (clock),
    .nrst      (nrst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .preempt   (preempt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment memory driven by the DUT, and the model's own copy.
  logic [DATA_W-1:0] mem  [2048];
  logic [DATA_W-1:0] mmem [2048];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    int              owner;
    int              last;
    int              hold;
    logic [NREQ-1:0] pe;
  } model_t;

  model_t            m;
  logic [NREQ-1:0]   m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic [NREQ-1:0]   e_grant;
  logic [ADDR_W-1:0] e_addr;
  logic              e_we;
  logic [DATA_W-1:0] e_wdata;

  function automatic int scan(input int from, input int excl, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (from + k) % NREQ;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic model_t step(input model_t s, input logic [NREQ-1:0] r);
    model_t          n;
    logic [NREQ-1:0] oth;
    n    = s;
    n.pe = '0;
    if (s.owner < 0) begin
      if (r != '0) begin
        n.owner = scan(s.last, -1, r);
        n.hold  = 0;
      end
    end else begin
      oth          = r;
      oth[s.owner] = 1'b0;
      if (!r[s.owner]) begin
        n.last  = s.owner;
        n.owner = scan(s.owner, s.owner, r);
        n.hold  = 0;
      end else if (oth != '0 && s.hold == MH - 1) begin
        n.pe[s.owner] = 1'b1;
        n.last        = s.owner;
        n.owner       = scan(s.owner, s.owner, r);
        n.hold        = 0;
      end else if (oth != '0 && s.hold < MH) begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  always_comb begin
    e_grant = '0;
    e_addr  = '0;
    e_we    = 1'b0;
    e_wdata = '0;
    if (m.owner >= 0) begin
      e_grant[m.owner] = 1'b1;
      e_addr  = req_addr[m.owner*ADDR_W +: ADDR_W];
      e_wdata = req_wdata[m.owner*DATA_W +: DATA_W];
      e_we    = req_we[m.owner] & req[m.owner];
    end
  end

  always @(posedge clock) begin
    if (!nrst) begin
      m.owner  <= -1;
      m.last   <= NREQ - 1;
      m.hold   <= 0;
      m.pe     <= '0;
      m_rvalid <= '0;
    end else begin
      m        <= step(m, req);
      m_rvalid <= e_grant & req & ~req_we;
      m_rdata  <= mmem[e_addr];
      if (e_we) mmem[e_addr] <= e_wdata;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model grant", 32'(grant), 32'(e_grant));
      check("model rvalid", 32'(rvalid), 32'(m_rvalid));
      check("model preempt", 32'(preempt), 32'(m.pe));
      check("model mem_we", 32'(mem_we), 32'(e_we));
      check("model mem_addr", 32'(mem_addr), 32'(e_addr));
      check("model mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      if (m_rvalid != '0) check("model rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic drive(input int i, input logic r, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[i]                     = r;
    req_we[i]                  = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      mem[a]  = 16'(a * 7 + 3);
      mmem[a] = 16'(a * 7 + 3);
    end
    mem[11'h152] = 16'h00A5;  mmem[11'h152] = 16'h00A5;
    mem[11'h1D2] = 16'hBEEF;  mmem[11'h1D2] = 16'hBEEF;
    mem[11'h04A] = 16'h0C0D;  mmem[11'h04A] = 16'h0C0D;

    nrst = 1'b0;
    clear_all();
    tick();
    chk_en = 1'b1;
    tick();
    neg();
    check("reset grant", 32'(grant), 32'h0);
    check("reset rvalid", 32'(rvalid), 32'h0);
    check("reset preempt", 32'(preempt), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);

    // Single requester read
    tick();
    nrst = 1'b1;
    drive(REQ_REWARD, 1'b1, 1'b0, word_addr(BATTERY_BASE, 5), '0);
    tick();
    neg();
    check("single grant", 32'(grant), 32'h1);
    check("single mem_addr", 32'(mem_addr), 32'h152);
    tick();
    drive(REQ_REWARD, 1'b0, 1'b0, '0, '0);
    neg();
    check("single rvalid", 32'(rvalid), 32'h1);
    check("single rdata", 32'(rdata), 32'h00A5);
    tick();
    tick();

    // Burst integrity
    drive(REQ_REWARD, 1'b1, 1'b0, 11'h152, '0);
    tick();
    neg();
    check("burst grant r1", 32'(grant), 32'h1);
    tick();
    drive(REQ_REWARD, 1'b1, 1'b0, word_addr(QVALUE_BASE, 5), '0);
    drive(REQ_BESTHOP, 1'b1, 1'b0, word_addr(NEIGHBOR_ID_BASE, 4), '0);
    neg();
    check("burst grant r2", 32'(grant), 32'h1);
    check("burst rdata r1", 32'(rdata), 32'h00A5);
    tick();
    drive(REQ_REWARD, 1'b1, 1'b0, word_addr(NEIGHBOR_ID_BASE, 1), '0);
    neg();
    check("burst grant r3", 32'(grant), 32'h1);
    check("burst rdata r2", 32'(rdata), 32'hBEEF);
    tick();
    drive(REQ_REWARD, 1'b0, 1'b0, '0, '0);
    neg();
    check("burst grant hold", 32'(grant), 32'h1);
    check("burst rdata r3", 32'(rdata), 32'h0C0D);
    tick();
    neg();
    check("burst handover", 32'(grant), 32'h2);
    tick();
    drive(REQ_BESTHOP, 1'b0, 1'b0, '0, '0);
    neg();
    check("burst rvalid req1", 32'(rvalid), 32'h2);
    tick();
    tick();

    // Round-robin fairness from a fresh reset
    nrst = 1'b0;
    tick();
    neg();
    check("rr reset grant", 32'(grant), 32'h0);
    nrst = 1'b1;
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b0, 11'(11'h100 + i), '0);
    tick();
    for (int s = 0; s < 4; s++) begin
      int o;
      o = s % NREQ;
      neg();
      check("rr order", 32'(grant), 32'(1 << o));
      tick();
      req[o] = 1'b0;
      tick();
      req[o] = 1'b1;
    end
    clear_all();
    tick();
    tick();

    // Write then read back
    drive(REQ_QUPDATE, 1'b1, 1'b1, QVALUE_BASE, 16'h1234);
    tick();
    neg();
    check("write grant", 32'(grant), 32'h4);
    check("write mem_we", 32'(mem_we), 32'h1);
    check("write mem_addr", 32'(mem_addr), 32'h1C8);
    check("write mem_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    drive(REQ_QUPDATE, 1'b1, 1'b0, QVALUE_BASE, '0);
    neg();
    check("write we drop", 32'(mem_we), 32'h0);
    check("write no rvalid", 32'(rvalid), 32'h0);
    tick();
    drive(REQ_QUPDATE, 1'b0, 1'b0, '0, '0);
    neg();
    check("readback rvalid", 32'(rvalid), 32'h4);
    check("readback rdata", 32'(rdata), 32'h1234);
    tick();
    tick();

    // Preemption by the hold watchdog
    drive(REQ_REWARD, 1'b1, 1'b0, 11'h14A, '0);
    tick();
    tick();
    tick();
    drive(REQ_BESTHOP, 1'b1, 1'b0, 11'h04C, '0);
    neg();
    check("pre lone grant", 32'(grant), 32'h1);
    tick();
    tick();
    tick();
    neg();
    check("pre grant before", 32'(grant), 32'h1);
    check("pre no pulse yet", 32'(preempt), 32'h0);
    tick();
    neg();
    check("pre grant moved", 32'(grant), 32'h2);
    check("pre pulse", 32'(preempt), 32'h1);
    check("pre last read", 32'(rvalid), 32'h1);
    tick();
    drive(REQ_BESTHOP, 1'b0, 1'b0, '0, '0);
    neg();
    check("pre pulse end", 32'(preempt), 32'h0);
    check("pre new rvalid", 32'(rvalid), 32'h2);
    tick();
    neg();
    check("pre regrant", 32'(grant), 32'h1);
    repeat (8) tick();
    neg();
    check("lone owner kept", 32'(grant), 32'h1);
    check("lone no preempt", 32'(preempt), 32'h0);

    // Reset during an owned read
    tick();
    nrst = 1'b0;
    tick();
    neg();
    check("mid reset grant", 32'(grant), 32'h0);
    check("mid reset rvalid", 32'(rvalid), 32'h0);
    check("mid reset mem_we", 32'(mem_we), 32'h0);
    nrst = 1'b1;
    drive(REQ_BESTHOP, 1'b1, 1'b0, 11'h050, '0);
    drive(REQ_QUPDATE, 1'b1, 1'b0, 11'h1CA, '0);
    tick();
    neg();
    check("post reset priority", 32'(grant), 32'h1);

    clear_all();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port node data memory (11-bit address, 16-bit data, 1-cycle synchronous read) between NREQ requester engines, e.g. reward, best-hop search and Q-update.
- The round-robin arbiter grants whole bursts: the owner keeps the port for as long as it holds req, so multi-read sequences such as battery-stat, then Q-value, then neighbour-ID are not interleaved.
- A hold watchdog preempts an owner that starves the other requesters.

Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 11, memory address width
- DATA_W, 16, memory word width
- MAX_HOLD, 64, max consecutive owned cycles while another req is pending before preemption

Ports:
- clock  in  1  system clock
- nrst  in  1  synchronous active-low reset
- req  in  NREQ  per-requester port request; held high for whole burst
- req_we  in  NREQ  per-requester write strobe, valid while granted
- req_addr  in  NREQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed; requester i at [i*DATA_W +: DATA_W]
- grant  out  NREQ  one-hot registered grant
- rdata  out  DATA_W  memory read data, broadcast to all requesters
- rvalid  out  NREQ  one-hot; rdata valid for requester i
- preempt  out  NREQ  one-cycle pulse on the requester whose grant was removed by the watchdog
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1 cycle after address

Behaviour:
- Reset, synchronous on nrst=0, wins over everything, including mid-burst:
  - grant=0, rvalid=0, preempt=0.
  - Priority pointer set so requester 0 has highest priority (last_owner=NREQ-1).
  - hold_cnt=0, state IDLE.
  - Any read in flight is discarded.
- States: IDLE (grant=0) and OWN (exactly one grant bit set).
- IDLE: if req!=0, register grant to the first set req scanning from last_owner+1 with wrap-around, then go to OWN. Otherwise stay in IDLE.
- OWN, owner req high, no preemption: grant held, hold_cnt increments, saturating at MAX_HOLD.
- OWN, owner req low on an edge: release with zero bubble.
  - last_owner=owner.
  - The new grant is picked from the other pending reqs on the same edge, via the round-robin scan. If none are pending, go to IDLE.
- Preemption: owner req high AND another req pending AND hold_cnt==MAX_HOLD-1 on an edge.
  - Grant moves to the next pending requester.
  - preempt[owner] pulses 1 cycle.
  - last_owner=owner.
  - The preempted requester must re-request; it keeps req high and waits its turn.
- hold_cnt resets to 0 on every grant change. It does not count while no other req is pending, so a lone owner is never preempted.
- Memory mux, combinational from the registered grant:
  - mem_addr, mem_we and mem_wdata come from the owner's slice.
  - When grant=0: mem_addr=0, mem_we=0, mem_wdata=0.
  - mem_we is forced 0 unless the owner's req is high.
- Read return:
  - rvalid is registered: rvalid_next[i] = grant[i] & req[i] & ~req_we[i].
  - rdata = mem_rdata directly; no extra register.
  - Read latency is address cycle + 1.
  - A read issued on the owner's last cycle still returns rvalid to that owner on the next cycle, even if grant has moved.
- Writes: take effect at the edge ending the cycle with mem_we=1. No rvalid is generated for a write.
- Requests are sampled only on edges. A req pulse shorter than a cycle that misses an edge is ignored.
- Requesters must not change addr/we/wdata relative to grant semantics; the arbiter does not buffer requests.

Decomposition:
- Shared package node_mem_pkg:
  - ADDR_W and DATA_W constants.
  - Memory map bases: NEIGHBOR_ID_BASE=11'h048, BATTERY_BASE=11'h148, QVALUE_BASE=11'h1C8; word stride 2.
  - Requester index constants: REQ_REWARD=0, REQ_BESTHOP=1, REQ_QUPDATE=2.
- One sub-module rr_pick: combinational round-robin picker. Inputs are the req vector, last_owner and an exclude mask; output is a one-hot pick plus a valid flag. It is instantiated once and used for IDLE, release and preemption.

Test Plan:
- Single requester:
  - Stimulus: reset, then req=3'b001 reading addr 0x152 with memory holding 0x00A5.
  - Response: grant=001 one cycle after req; mem_addr=0x152; rvalid=001 and rdata=0x00A5 on the next cycle.
- Burst integrity:
  - Stimulus: req0 holds for 3 reads (0x152, 0x1D2, 0x04A) while req1 rises on cycle 2.
  - Response: grant stays 001 for all 3 reads. Grant becomes 010 on the same edge req0 drops, with no idle cycle.
- Round-robin fairness:
  - Stimulus: all three reqs held; each releases after 2 cycles and immediately re-requests.
  - Response: grant order 001, 010, 100, 001.
- Write:
  - Stimulus: req2 writes 0x1234 to 0x1C8, then reads 0x1C8.
  - Response: mem_we high for exactly 1 cycle; the read returns 0x1234 with rvalid=100 and no rvalid on the write.
- Preemption:
  - Stimulus: MAX_HOLD=4; req0 held indefinitely; req1 rises.
  - Response: grant moves to 010 after 4 owned cycles counted from req1 pending; preempt=001 for 1 cycle.
- Reset mid-burst:
  - Stimulus: nrst=0 during an owned read.
  - Response: the next cycle shows grant=0, rvalid=0, mem_we=0, and after release requester 0 is top priority.
